// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch, prioritised redirects, stall buffering
// of one pending redirect, and alignment trapping of branch/jump targets.
module pc_unit #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           INST_BYTES   = 4,
  parameter int unsigned           ALIGN_BITS   = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(32'h0000_0020)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall,
  input  logic                  i_exc,
  input  logic                  i_branch_taken,
  input  logic [ADDR_WIDTH-1:0] i_branch_target,
  input  logic                  i_jump,
  input  logic [ADDR_WIDTH-1:0] i_jump_target,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_ce,
  output logic [ADDR_WIDTH-1:0] o_pc_seq,
  output logic                  o_pending,
  output logic                  o_addr_err,
  output logic [ADDR_WIDTH-1:0] o_bad_addr
);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_HOLD} state_t;

  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_JMP  = 2'd1;
  localparam logic [1:0] CLS_BR   = 2'd2;
  localparam logic [1:0] CLS_EXC  = 2'd3;

  // Zero mask when ALIGN_BITS is 0, which disables the check entirely.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic                  r_ce, w_ce_nxt;
  logic                  r_pend, w_pend_nxt;
  logic [ADDR_WIDTH-1:0] r_buf_tgt, w_buf_tgt_nxt;
  logic [1:0]            r_buf_cls, w_buf_cls_nxt;
  logic                  r_addr_err, w_addr_err_nxt;
  logic [ADDR_WIDTH-1:0] r_bad_addr, w_bad_addr_nxt;

  logic [ADDR_WIDTH-1:0] w_pc_seq;
  logic [1:0]            w_new_cls;
  logic [ADDR_WIDTH-1:0] w_new_tgt;
  logic                  w_apply;
  logic [1:0]            w_app_cls;
  logic [ADDR_WIDTH-1:0] w_app_tgt;

  assign w_pc_seq = r_pc + ADDR_WIDTH'(INST_BYTES);

  always_comb begin
    w_new_cls = CLS_NONE;
    w_new_tgt = w_pc_seq;
    if (i_exc) begin
      w_new_cls = CLS_EXC;
      w_new_tgt = EXC_VECTOR;
    end else if (i_branch_taken) begin
      w_new_cls = CLS_BR;
      w_new_tgt = i_branch_target;
    end else if (i_jump) begin
      w_new_cls = CLS_JMP;
      w_new_tgt = i_jump_target;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ce_nxt       = r_ce;
    w_pend_nxt     = r_pend;
    w_buf_tgt_nxt  = r_buf_tgt;
    w_buf_cls_nxt  = r_buf_cls;
    w_addr_err_nxt = 1'b0;
    w_bad_addr_nxt = r_bad_addr;
    w_apply        = 1'b0;
    w_app_cls      = w_new_cls;
    w_app_tgt      = w_new_tgt;

    unique case (r_state)
      S_RESET: begin
        w_ce_nxt    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!i_stall) begin
          w_apply = 1'b1;
        end else if (w_new_cls != CLS_NONE) begin
          w_buf_tgt_nxt = w_new_tgt;
          w_buf_cls_nxt = w_new_cls;
          w_pend_nxt    = 1'b1;
          w_state_nxt   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_stall) begin
          if (w_new_cls != CLS_NONE && w_new_cls >= r_buf_cls) begin
            w_buf_tgt_nxt = w_new_tgt;
            w_buf_cls_nxt = w_new_cls;
          end
        end else begin
          // Buffered class is never NONE, so an idle release always takes the buffer.
          w_apply = 1'b1;
          if (w_new_cls < r_buf_cls) begin
            w_app_cls = r_buf_cls;
            w_app_tgt = r_buf_tgt;
          end
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RESET;
    endcase

    if (w_apply) begin
      if ((w_app_cls == CLS_BR || w_app_cls == CLS_JMP) && ((w_app_tgt & ALIGN_MASK) != '0)) begin
        w_pc_nxt       = EXC_VECTOR;
        w_addr_err_nxt = 1'b1;
        w_bad_addr_nxt = w_app_tgt;
      end else begin
        w_pc_nxt = w_app_tgt;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_RESET;
      r_pc       <= RESET_VECTOR;
      r_ce       <= 1'b0;
      r_pend     <= 1'b0;
      r_buf_tgt  <= '0;
      r_buf_cls  <= CLS_NONE;
      r_addr_err <= 1'b0;
      r_bad_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ce       <= w_ce_nxt;
      r_pend     <= w_pend_nxt;
      r_buf_tgt  <= w_buf_tgt_nxt;
      r_buf_cls  <= w_buf_cls_nxt;
      r_addr_err <= w_addr_err_nxt;
      r_bad_addr <= w_bad_addr_nxt;
    end
  end

  assign o_pc       = r_pc;
  assign o_ce       = r_ce;
  assign o_pc_seq   = w_pc_seq;
  assign o_pending  = r_pend;
  assign o_addr_err = r_addr_err;
  assign o_bad_addr = r_bad_addr;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit/4-byte instance and a 16-bit/2-byte instance.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, exc, br, jmp;
  logic [31:0] br_tgt, jmp_tgt;
  logic [31:0] pc, pc_seq, bad;
  logic        ce, pend, err;

  logic        s16, e16, b16, j16;
  logic [15:0] bt16, jt16;
  logic [15:0] pc16, seq16, bad16;
  logic        ce16, pend16, err16;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_unit #(.ADDR_WIDTH(32), .INST_BYTES(4), .ALIGN_BITS(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_exc(exc),
    .i_branch_taken(br), .i_branch_target(br_tgt), .i_jump(jmp), .i_jump_target(jmp_tgt),
    .o_pc(pc), .o_ce(ce), .o_pc_seq(pc_seq), .o_pending(pend),
    .o_addr_err(err), .o_bad_addr(bad)
  );

  pc_unit #(.ADDR_WIDTH(16), .INST_BYTES(2), .ALIGN_BITS(1)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(s16), .i_exc(e16),
    .i_branch_taken(b16), .i_branch_target(bt16), .i_jump(j16), .i_jump_target(jt16),
    .o_pc(pc16), .o_ce(ce16), .o_pc_seq(seq16), .o_pending(pend16),
    .o_addr_err(err16), .o_bad_addr(bad16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; exc = 0; br = 0; jmp = 0; br_tgt = 0; jmp_tgt = 0;
    s16 = 0; e16 = 0; b16 = 0; j16 = 0; bt16 = 0; jt16 = 0;

    // Reset state
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_ce", {31'b0, ce}, 32'h0);
    check("rst_pend", {31'b0, pend}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_bad", bad, 32'h0);

    // Release: ce rises one edge later with pc still at the reset vector
    rst_n = 1'b1;
    tick();
    check("t1_ce", {31'b0, ce}, 32'h1);
    check("t1_pc0", pc, 32'h0);
    tick(); check("t1_pc4", pc, 32'h4);
    tick(); check("t1_pc8", pc, 32'h8);
    tick(); check("t1_pc12", pc, 32'hc);
    check("t1_seq", pc_seq, 32'h10);

    // Branch, then exc beating branch
    br = 1; br_tgt = 32'h100;
    tick(); check("t2_br", pc, 32'h100);
    br = 0;
    tick(); check("t2_seq", pc, 32'h104);
    br = 1; exc = 1;
    tick(); check("t2_exc", pc, 32'h20);
    br = 0; exc = 0;
    tick(); check("t2_after", pc, 32'h24);

    // Stall buffering: jump, then branch replaces, then lower-class jump ignored
    stall = 1; jmp = 1; jmp_tgt = 32'h200;
    tick(); check("t3_hold1", pc, 32'h24); check("t3_pend1", {31'b0, pend}, 32'h1);
    jmp = 0; br = 1; br_tgt = 32'h300;
    tick(); check("t3_hold2", pc, 32'h24);
    br = 0; jmp = 1; jmp_tgt = 32'h400;
    tick(); check("t3_hold3", pc, 32'h24); check("t3_ce", {31'b0, ce}, 32'h1);
    jmp = 0; stall = 0;
    tick(); check("t3_rel", pc, 32'h300); check("t3_pend0", {31'b0, pend}, 32'h0);
    tick(); check("t3_seq", pc, 32'h304);

    // Tie on release: new request wins over the buffer
    stall = 1; br = 1; br_tgt = 32'h300;
    tick();
    br = 0; jmp = 1; jmp_tgt = 32'h400;
    tick(); check("t4_hold", pc, 32'h304);
    jmp = 0; stall = 0; br = 1; br_tgt = 32'h500;
    tick(); check("t4_tie", pc, 32'h500); check("t4_pend", {31'b0, pend}, 32'h0);
    br = 0;

    // Misaligned jump traps
    jmp = 1; jmp_tgt = 32'h102;
    tick();
    check("t5_pc", pc, 32'h20); check("t5_err", {31'b0, err}, 32'h1);
    check("t5_bad", bad, 32'h102);
    jmp = 0;
    tick();
    check("t5_err0", {31'b0, err}, 32'h0); check("t5_bad_hold", bad, 32'h102);
    check("t5_pc2", pc, 32'h24);

    // Misaligned target from the buffer also traps
    stall = 1; br = 1; br_tgt = 32'h106;
    tick(); check("t5b_hold", pc, 32'h24);
    stall = 0; br = 0;
    tick();
    check("t5b_pc", pc, 32'h20); check("t5b_err", {31'b0, err}, 32'h1);
    check("t5b_bad", bad, 32'h106);

    // Asynchronous reset mid-cycle while a redirect is pending
    stall = 1; br = 1; br_tgt = 32'h300;
    tick(); check("t6_pend", {31'b0, pend}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_pc", pc, 32'h0); check("t6_ce", {31'b0, ce}, 32'h0);
    check("t6_pend0", {31'b0, pend}, 32'h0); check("t6_bad", bad, 32'h0);
    stall = 0; br = 0;
    tick();
    rst_n = 1'b1;
    tick(); check("t6_pc0", pc, 32'h0); check("t6_ce1", {31'b0, ce}, 32'h1);
    tick(); check("t6_pc4", pc, 32'h4);
    tick(); check("t6_pc8", pc, 32'h8);

    // 16-bit, 2-byte instance: step of 2, odd target traps, even does not, wrap to 0
    check("w_pc_step", {16'b0, pc16}, 32'h4);
    j16 = 1; jt16 = 16'h0101;
    tick();
    check("w_trap_pc", {16'b0, pc16}, 32'h20); check("w_trap_err", {31'b0, err16}, 32'h1);
    check("w_trap_bad", {16'b0, bad16}, 32'h101);
    jt16 = 16'h0102;
    tick();
    check("w_ok_pc", {16'b0, pc16}, 32'h102); check("w_ok_err", {31'b0, err16}, 32'h0);
    jt16 = 16'hfffe;
    tick();
    check("w_top_pc", {16'b0, pc16}, 32'hfffe); check("w_top_seq", {16'b0, seq16}, 32'h0);
    j16 = 0;
    tick();
    check("w_wrap", {16'b0, pc16}, 32'h0); check("w_wrap_err", {31'b0, err16}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle/pipelined CPU datapath; drives the instruction-fetch address and the instruction-memory enable.
- Supports sequential increment, branch, jump and exception redirects, with stall handling and a one-entry pending-redirect buffer.
- Checks redirect alignment and traps misaligned targets to the exception vector.

Parameters:
ADDR_WIDTH, 32, width of pc and all target addresses
INST_BYTES, 4, bytes per instruction; sequential increment amount; power of two ≥1
ALIGN_BITS, 2, log2(INST_BYTES); low target bits that must be zero
RESET_VECTOR, 0, pc value held during and after reset
EXC_VECTOR, 32'h0000_0020, pc loaded on exception or misaligned redirect (truncated to ADDR_WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
stall  in  1  hold pc; redirects arriving now are buffered
exc  in  1  exception request, class 3
branch_taken  in  1  taken branch, class 2
branch_target  in  ADDR_WIDTH  branch destination
jump  in  1  jump, class 1
jump_target  in  ADDR_WIDTH  jump destination
pc  out  ADDR_WIDTH  current fetch address
ce  out  1  instruction-memory enable
pc_seq  out  ADDR_WIDTH  combinational pc + INST_BYTES, wraps modulo 2^ADDR_WIDTH
pending  out  1  a buffered redirect is waiting
addr_err  out  1  one-cycle pulse: misaligned redirect trapped
bad_addr  out  ADDR_WIDTH  offending target, held until next trap

Behaviour:
- Reset: one clock, clk; rst is asynchronous and active-low. While rst=0: pc=RESET_VECTOR, ce=0, pending=0, addr_err=0, bad_addr=0, state=S_RESET.
- FSM states: S_RESET, S_RUN, S_HOLD.
- S_RESET:
  - First posedge with rst=1: ce<=1, pc unchanged, go to S_RUN.
  - The first fetch is therefore RESET_VECTOR, issued one cycle after reset release.
- S_RUN, stall=0:
  - Selected target = highest active class: exc → EXC_VECTOR; branch → branch_target; jump → jump_target; none → pc_seq.
  - pc <= selected target.
- S_RUN, stall=1:
  - pc holds.
  - If any redirect is active, latch its target and class into the buffer, pending<=1, go to S_HOLD.
- S_HOLD, stall=1:
  - pc holds.
  - A new redirect replaces the buffer when new class ≥ buffered class; otherwise it is ignored.
- S_HOLD, stall=0:
  - Compare the buffer with any same-cycle request; the higher class wins, and on a tie the new request wins.
  - pc <= winner, pending<=0, go to S_RUN.
  - Redirect-apply latency after stall release is exactly one edge.
- Alignment check:
  - Applies to branch and jump targets when applied to pc, whether direct or from the buffer.
  - If target[ALIGN_BITS-1:0]≠0: pc <= EXC_VECTOR, addr_err=1 for that one cycle, bad_addr <= target.
  - exc and sequential values are never checked.
  - When ALIGN_BITS=0, no check is performed.
- Wrap-around: pc_seq from the all-ones-aligned top address wraps to 0 with no flag.
- ce stays 1 in S_RUN and S_HOLD; it drops only on reset.
- Reset mid-stall or mid-pending: the buffer is cleared immediately and pending=0. After release, the block restarts from S_RESET with no replay.
- Single registered process for pc/ce/state/buffer; pc_seq is combinational.
- Expected size: about 150–220 lines of RTL.

Test Plan:
1. Reset release, no requests. pc: 0 while ce=0 → then 0, 4, 8, 12… one per cycle. ce rises exactly one edge after rst goes high.
2. branch_taken=1 with branch_target=0x100 while running. Next pc=0x100, then 0x104. Same cycle with exc=1 as well: pc=0x20 (exc beats branch).
3. stall=1 for 3 cycles, with jump to 0x200 in cycle 1 and branch to 0x300 in cycle 2. pc holds, pending=1, buffer ends at 0x300. When stall drops, pc=0x300 on the next edge and pending=0.
4. While stalled with branch 0x300 buffered, jump 0x400 arrives. The jump is ignored. Release stall with a simultaneous branch to 0x500: pc=0x500 (tie goes to the new request).
5. jump_target=0x102. pc=0x20, addr_err pulses for 1 cycle, bad_addr=0x102. Repeat with ADDR_WIDTH=16, INST_BYTES=2: 0x101 traps, 0x102 does not.
6. Assert rst=0 asynchronously mid-cycle during S_HOLD with pending=1. pc=0 and ce=0 immediately, pending=0. After release, the sequence of test 1 repeats.
